acc_sad_sequencer: RTL and testbench

Control sequencer between the HPS-side QSYS streaming/PIO interfaces and the SAD accelerator core. It decodes 32-bit command words from the accelerator config channel, loads lambda, and gates a fixed-length original-block transfer into the core. It then starts the core, latches the 64-bit SAD result and publishes the PIO status bits that software polls.

---
 rtl/acc_sad_sequencer.sv | 177 +++++++++++++++++
 tb/tb_acc_sad_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sad_sequencer.sv
// Command sequencer between the HPS config/orig-block streams and the SAD core.
// Optional RUN watchdog enabled by defining SEQ_TIMEOUT_EN.
module acc_sad_sequencer #(
  parameter int unsigned LCU_WORDS      = 1024,
  parameter int unsigned CNT_W          = 11,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cfg_data_in,
  input  logic        cfg_lz_in,
  output logic        cfg_vz_out,
  input  logic        orig_lz_in,
  output logic        orig_vz_out,
  input  logic        core_orig_ready_in,
  output logic        core_orig_valid_out,
  output logic [31:0] core_lambda_out,
  output logic        core_start_out,
  input  logic        core_done_in,
  input  logic [63:0] core_sad_in,
  output logic [31:0] sad_result_low_out,
  output logic [31:0] sad_result_high_out,
  output logic        lambda_loaded_out,
  output logic        lcu_loaded_out,
  output logic [1:0]  result_ready_out,
  output logic        clear_fifo_out
);

  localparam logic [3:0] OP_SET_LAMBDA = 4'h1;
  localparam logic [3:0] OP_LOAD_LCU   = 4'h2;
  localparam logic [3:0] OP_START      = 4'h3;
  localparam logic [3:0] OP_CLEAR      = 4'hF;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LCU_WORDS - 1);

  // Elaboration-time parameter sanity.
  if ((64'(1) << CNT_W) <= 64'(LCU_WORDS)) begin : g_bad_cnt_w
    $error("acc_sad_sequencer: CNT_W too narrow for LCU_WORDS");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("acc_sad_sequencer: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAMBDA,
    S_LOAD,
    S_RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [3:0]       opcode;
  logic             cfg_fire;
  logic             orig_fire;
  logic             in_load;

  assign opcode    = cfg_data_in[31:28];
  assign cfg_fire  = cfg_lz_in & cfg_vz_out;
  assign in_load   = (state == S_LOAD);
  assign orig_fire = in_load & orig_lz_in & core_orig_ready_in;

  // Orig-block handshake is passed through with zero latency while loading.
  assign orig_vz_out         = in_load & core_orig_ready_in;
  assign core_orig_valid_out = in_load & orig_lz_in;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
  logic        wd_expire;
  assign wd_expire = (wd_cnt == WD_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      beat_cnt            <= '0;
      cfg_vz_out          <= 1'b0;
      core_lambda_out     <= '0;
      core_start_out      <= 1'b0;
      sad_result_low_out  <= '0;
      sad_result_high_out <= '0;
      lambda_loaded_out   <= 1'b0;
      lcu_loaded_out      <= 1'b0;
      result_ready_out    <= 2'b00;
      clear_fifo_out      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt              <= '0;
`endif
    end else begin
      core_start_out <= 1'b0;
      clear_fifo_out <= 1'b0;
      case (state)
        S_IDLE: begin
          cfg_vz_out <= 1'b1;
          if (cfg_fire) begin
            case (opcode)
              OP_SET_LAMBDA: state <= S_LAMBDA;
              OP_LOAD_LCU: begin
                state          <= S_LOAD;
                cfg_vz_out     <= 1'b0;
                lcu_loaded_out <= 1'b0;
              end
              OP_START: begin
                if (lambda_loaded_out && lcu_loaded_out) begin
                  state               <= S_RUN;
                  cfg_vz_out          <= 1'b0;
                  core_start_out      <= 1'b1;
                  result_ready_out[0] <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                  wd_cnt              <= '0;
`endif
                end else begin
                  result_ready_out[1] <= 1'b1;
                end
              end
              OP_CLEAR: begin
                clear_fifo_out    <= 1'b1;
                beat_cnt          <= '0;
                lcu_loaded_out    <= 1'b0;
                lambda_loaded_out <= 1'b0;
                result_ready_out  <= 2'b00;
              end
              default: result_ready_out[1] <= 1'b1;
            endcase
          end
        end

        S_LAMBDA: begin
          if (cfg_fire) begin
            core_lambda_out   <= cfg_data_in;
            lambda_loaded_out <= 1'b1;
            state             <= S_IDLE;
          end
        end

        S_LOAD: begin
          if (orig_fire) begin
            if (beat_cnt == CNT_LAST) begin
              beat_cnt       <= '0;
              lcu_loaded_out <= 1'b1;
              cfg_vz_out     <= 1'b1;
              state          <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end

        S_RUN: begin
          if (core_done_in) begin
            sad_result_low_out  <= core_sad_in[31:0];
            sad_result_high_out <= core_sad_in[63:32];
            result_ready_out[0] <= 1'b1;
            lcu_loaded_out      <= 1'b0;
            cfg_vz_out          <= 1'b1;
            state               <= S_IDLE;
          end
`ifdef SEQ_TIMEOUT_EN
          // Watchdog abort: flag error and flush the streams, keep the old SAD.
          else if (wd_expire) begin
            result_ready_out[1] <= 1'b1;
            clear_fifo_out      <= 1'b1;
            lcu_loaded_out      <= 1'b0;
            cfg_vz_out          <= 1'b1;
            state               <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sad_sequencer.sv
// Scoreboard bench for acc_sad_sequencer: directed command/stream vectors,
// expected start/clear/result events queued and checked by a monitor.
module tb_acc_sad_sequencer;

  localparam int EV_START  = 1;
  localparam int EV_CLEAR  = 2;
  localparam int EV_RESULT = 3;

  typedef struct {
    int          kind;
    logic [63:0] val;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_data_in;
  logic        cfg_lz_in;
  logic        cfg_vz_out;
  logic        orig_lz_in;
  logic        orig_vz_out;
  logic        core_orig_ready_in;
  logic        core_orig_valid_out;
  logic [31:0] core_lambda_out;
  logic        core_start_out;
  logic        core_done_in;
  logic [63:0] core_sad_in;
  logic [31:0] sad_result_low_out;
  logic [31:0] sad_result_high_out;
  logic        lambda_loaded_out;
  logic        lcu_loaded_out;
  logic [1:0]  result_ready_out;
  logic        clear_fifo_out;

  int  n_chk  = 0;
  int  n_pass = 0;
  ev_t exp_q[$];
  logic rr0_q = 1'b0;

  acc_sad_sequencer #(
    .LCU_WORDS(1024),
    .CNT_W(11),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_data_in(cfg_data_in),
    .cfg_lz_in(cfg_lz_in),
    .cfg_vz_out(cfg_vz_out),
    .orig_lz_in(orig_lz_in),
    .orig_vz_out(orig_vz_out),
    .core_orig_ready_in(core_orig_ready_in),
    .core_orig_valid_out(core_orig_valid_out),
    .core_lambda_out(core_lambda_out),
    .core_start_out(core_start_out),
    .core_done_in(core_done_in),
    .core_sad_in(core_sad_in),
    .sad_result_low_out(sad_result_low_out),
    .sad_result_high_out(sad_result_high_out),
    .lambda_loaded_out(lambda_loaded_out),
    .lcu_loaded_out(lcu_loaded_out),
    .result_ready_out(result_ready_out),
    .clear_fifo_out(clear_fifo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push_ev(input int kind, input logic [63:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic see_ev(input int kind, input logic [63:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 64'(kind), 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (kind == EV_RESULT) chk("event_sad", val, e.val);
    end
  endtask

  // Monitor: every pulse / result rise must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start_out) see_ev(EV_START, 64'd0);
      if (clear_fifo_out) see_ev(EV_CLEAR, 64'd0);
      if (result_ready_out[0] && !rr0_q)
        see_ev(EV_RESULT, {sad_result_high_out, sad_result_low_out});
    end
    rr0_q = result_ready_out[0];
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [31:0] w);
    int n = 0;
    while (!cfg_vz_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cfg_vz_out) chk("cfg_accept_timeout", 64'd0, 64'd1);
    cfg_data_in = w;
    cfg_lz_in   = 1'b1;
    @(posedge clk);
    #1;
    cfg_lz_in   = 1'b0;
    cfg_data_in = '0;
  endtask

  task automatic pulse_done(input logic [63:0] sad);
    core_sad_in  = sad;
    core_done_in = 1'b1;
    @(posedge clk);
    #1;
    core_done_in = 1'b0;
  endtask

  // Drive n orig handshakes; checks pass-through and that lcu_loaded stays low.
  task automatic stream(input int n, input bit bp);
    int   hs  = 0;
    int   cyc = 0;
    int   bad = 0;
    logic rdy;
    logic lz;
    while (hs < n && cyc < 20000) begin
      rdy = bp ? cyc[0] : 1'b1;
      lz  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      core_orig_ready_in = rdy;
      orig_lz_in         = lz;
      @(negedge clk);
      if (orig_vz_out !== rdy || core_orig_valid_out !== lz) bad++;
      if (lcu_loaded_out !== 1'b0) bad++;
      if (rdy && lz) hs++;
      @(posedge clk);
      #1;
      cyc++;
    end
    orig_lz_in         = 1'b0;
    core_orig_ready_in = 1'b0;
    chk("stream_beats", 64'(hs), 64'(n));
    chk("stream_passthru", 64'(bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cfg_data_in = '0;
    cfg_lz_in = 1'b0;
    orig_lz_in = 1'b0;
    core_orig_ready_in = 1'b1;
    core_done_in = 1'b0;
    core_sad_in = '0;
    #2;
    chk("rst_status", {58'd0, lambda_loaded_out, lcu_loaded_out, result_ready_out, cfg_vz_out,
                       orig_vz_out}, 64'd0);
    chk("rst_sad", {sad_result_high_out, sad_result_low_out}, 64'd0);
    chk("rst_pulses", {61'd0, core_start_out, clear_fifo_out, core_orig_valid_out}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    core_orig_ready_in = 1'b0;
    idle(2);
    chk("idle_cfg_vz", 64'(cfg_vz_out), 64'd1);

    // Nominal run
    send_cfg(32'h1000_0000);
    send_cfg(32'h0000_0040);
    chk("lambda_val", 64'(core_lambda_out), 64'h40);
    chk("lambda_loaded", 64'(lambda_loaded_out), 64'd1);
    send_cfg(32'h2000_0000);
    chk("load_cfg_vz", 64'(cfg_vz_out), 64'd0);
    stream(1024, 1'b0);
    chk("lcu_loaded_nom", 64'(lcu_loaded_out), 64'd1);
    push_ev(EV_START, 64'd0);
    send_cfg(32'h3000_0000);
    idle(3);
    push_ev(EV_RESULT, 64'h0000_0001_0000_00A5);
    pulse_done(64'h0000_0001_0000_00A5);
    chk("nom_sad_hi", 64'(sad_result_high_out), 64'h1);
    chk("nom_sad_lo", 64'(sad_result_low_out), 64'hA5);
    chk("nom_rr", 64'(result_ready_out), 64'b01);
    chk("nom_lcu_consumed", 64'(lcu_loaded_out), 64'd0);
    chk("nom_lambda_kept", 64'(lambda_loaded_out), 64'd1);

    // Backpressured load, then a second run clears result bit 0 at start
    send_cfg(32'h2000_0000);
    stream(1024, 1'b1);
    chk("lcu_loaded_bp", 64'(lcu_loaded_out), 64'd1);
    push_ev(EV_START, 64'd0);
    send_cfg(32'h3000_0000);
    chk("start_clears_rr0", 64'(result_ready_out), 64'b00);
    idle(2);
    push_ev(EV_RESULT, 64'hDEAD_BEEF_1234_5678);
    pulse_done(64'hDEAD_BEEF_1234_5678);
    chk("bp_rr", 64'(result_ready_out), 64'b01);

    // Reload twice: re-entry clears lcu_loaded; reset at beat 500
    send_cfg(32'h2000_0000);
    stream(1024, 1'b0);
    send_cfg(32'h2000_0000);
    chk("reload_clears_lcu", 64'(lcu_loaded_out), 64'd0);
    stream(500, 1'b0);
    core_orig_ready_in = 1'b1;
    orig_lz_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_status", {58'd0, lambda_loaded_out, lcu_loaded_out, result_ready_out, cfg_vz_out,
                          orig_vz_out}, 64'd0);
    chk("midrst_sad", {sad_result_high_out, sad_result_low_out}, 64'd0);
    chk("midrst_valid", 64'(core_orig_valid_out), 64'd0);
    core_orig_ready_in = 1'b0;
    orig_lz_in = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Illegal start, then CLEAR
    send_cfg(32'h3000_0000);
    idle(3);
    chk("illegal_start_rr", 64'(result_ready_out), 64'b10);
    chk("illegal_start_idle", 64'(cfg_vz_out), 64'd1);
    push_ev(EV_CLEAR, 64'd0);
    send_cfg(32'hF000_0000);
    idle(1);
    chk("clear_rr", 64'(result_ready_out), 64'b00);

    // Full 1024 beats needed after reset
    send_cfg(32'h2000_0000);
    stream(1023, 1'b0);
    chk("lcu_not_at_1023", 64'(lcu_loaded_out), 64'd0);
    stream(1, 1'b0);
    chk("lcu_at_1024", 64'(lcu_loaded_out), 64'd1);
    send_cfg(32'h1000_0000);
    send_cfg(32'h0000_0011);
    push_ev(EV_START, 64'd0);
    send_cfg(32'h3000_0000);
    idle(5);
    push_ev(EV_RESULT, 64'h0000_0000_0000_0777);
    pulse_done(64'h0000_0000_0000_0777);
    chk("run3_sad_lo", 64'(sad_result_low_out), 64'h777);

    // Unknown opcode keeps IDLE and sets sticky error; SET_LAMBDA still works
    send_cfg(32'h7000_0000);
    idle(1);
    chk("unknown_rr", 64'(result_ready_out), 64'b11);
    chk("unknown_idle", 64'(cfg_vz_out), 64'd1);
    send_cfg(32'h1000_0000);
    send_cfg(32'h0000_0099);
    chk("lambda_after_err", 64'(core_lambda_out), 64'h99);
    chk("err_sticky", 64'(result_ready_out), 64'b11);

    // Stray done in IDLE is ignored
    pulse_done(64'h1111_2222_3333_4444);
    idle(1);
    chk("stray_done_sad", {sad_result_high_out, sad_result_low_out}, 64'h777);
    chk("stray_done_rr", 64'(result_ready_out), 64'b11);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: RUN aborts after 100 cycles without done
    push_ev(EV_CLEAR, 64'd0);
    send_cfg(32'hF000_0000);
    send_cfg(32'h1000_0000);
    send_cfg(32'h0000_0022);
    send_cfg(32'h2000_0000);
    stream(1024, 1'b0);
    push_ev(EV_START, 64'd0);
    push_ev(EV_CLEAR, 64'd0);
    send_cfg(32'h3000_0000);
    idle(90);
    chk("wd_still_run", 64'(result_ready_out), 64'b00);
    idle(15);
    chk("wd_rr", 64'(result_ready_out), 64'b10);
    chk("wd_idle", 64'(cfg_vz_out), 64'd1);
    chk("wd_lcu", 64'(lcu_loaded_out), 64'd0);
    pulse_done(64'h5555_6666_7777_8888);
    idle(1);
    chk("wd_late_done_sad", {sad_result_high_out, sad_result_low_out}, 64'h777);
`endif

    idle(3);
    chk("event_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
